// File: rtl/bram_sdp_fifo_if.sv
// bram_sdp_fifo_if: write/read/status bundle between a streaming client and the BRAM FIFO.
// Latency: none (wires only); the FIFO registers every output it drives here.
// Backpressure: the client must honour full/empty; rejected requests only touch ovf/udf.
//
// Signals
//   din, wr_en              write data and write request          (client -> FIFO)
//   rd_en                   read request                          (client -> FIFO)
//   err_clr                 clears sticky ovf/udf                 (client -> FIFO)
//   full, almost_full       occupancy == DEPTH / >= AF_LVL        (FIFO -> client)
//   empty, almost_empty     occupancy == 0 / <= AE_LVL            (FIFO -> client)
//   dout, dout_vld          registered read data, 1-cycle strobe  (FIFO -> client)
//   count                   occupancy 0..DEPTH                    (FIFO -> client)
//   ovf, udf                sticky overflow / underflow           (FIFO -> client)
// Modports: master = client side, slave = FIFO side.
interface bram_sdp_fifo_if #(
  parameter int A_WID = 9,
  parameter int D_WID = 32
);
  logic [D_WID-1:0] din;
  logic             wr_en;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [D_WID-1:0] dout;
  logic             dout_vld;
  logic             empty;
  logic             almost_empty;
  logic [A_WID:0]   count;
  logic             err_clr;
  logic             ovf;
  logic             udf;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  full, almost_full, dout, dout_vld, empty, almost_empty, count, ovf, udf
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output full, almost_full, dout, dout_vld, empty, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/bram_sdp_fifo.sv
// bram_sdp_fifo: single-clock FIFO on an inferred simple-dual-port block RAM.
// Latency: read data 1 cycle after an accepted rd_en; flags/count update 1 cycle after accept.
// Backpressure: writes refused while full, reads refused while empty (no bypass).
//
// Ports
//   clk    single clock, rising edge
//   rst_n  asynchronous, active-low reset (memory contents are not cleared)
//   bus    bram_sdp_fifo_if.slave: din/wr_en, rd_en, dout/dout_vld, full/almost_full,
//          empty/almost_empty, count, err_clr, ovf/udf
// Build option
//   BRAM_FIFO_ERR_EN  when defined, ovf/udf are sticky error flags cleared by err_clr;
//                     otherwise ovf = udf = 0 and err_clr is ignored.
module bram_sdp_fifo #(
  parameter int A_WID  = 9,
  parameter int D_WID  = 32,
  parameter int AF_LVL = 480,
  parameter int AE_LVL = 32
) (
  input  logic clk,
  input  logic rst_n,
  bram_sdp_fifo_if.slave bus
);

  localparam int DEPTH = 1 << A_WID;
  localparam logic [A_WID:0] DEPTH_C = (A_WID+1)'(DEPTH);
  localparam logic [A_WID:0] AF_C    = (A_WID+1)'(AF_LVL);
  localparam logic [A_WID:0] AE_C    = (A_WID+1)'(AE_LVL);

  // Storage: no reset so it maps onto block RAM.
  logic [D_WID-1:0] mem [DEPTH];

  logic [A_WID-1:0] wptr;
  logic [A_WID-1:0] rptr;
  logic [A_WID:0]   cnt_q;
  logic [A_WID:0]   cnt_nxt;

  logic             full_q;
  logic             afull_q;
  logic             empty_q;
  logic             aempty_q;
  logic [D_WID-1:0] dout_q;
  logic             dout_vld_q;

  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags, so a full FIFO refuses a write even
  // when a read is accepted in the same cycle, and an empty FIFO never bypasses.
  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;

  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_acc && !rd_acc)
      cnt_nxt = cnt_q + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_nxt = cnt_q - 1'b1;
  end

  // Write port. wptr == rptr only when empty or full, and one side is then
  // blocked, so the two ports never touch the same address in one cycle.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr] <= bus.din;
  end

  // Pointers, occupancy, registered read data and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wptr + 1'b1;   // wraps naturally: DEPTH is a power of two
      if (rd_acc) begin
        rptr   <= rptr + 1'b1;
        dout_q <= mem[rptr];
      end
      dout_vld_q <= rd_acc;
      cnt_q      <= cnt_nxt;
      // Flags are derived from the next count so they line up with count.
      full_q     <= (cnt_nxt == DEPTH_C);
      afull_q    <= (cnt_nxt >= AF_C);
      empty_q    <= (cnt_nxt == '0);
      aempty_q   <= (cnt_nxt <= AE_C);
    end
  end

`ifdef BRAM_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags; a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_q)
        ovf_q <= 1'b1;
      else if (bus.err_clr)
        ovf_q <= 1'b0;
      if (bus.rd_en && empty_q)
        udf_q <= 1'b1;
      else if (bus.err_clr)
        udf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  // Error tracking disabled: flags tied low, err_clr deliberately ignored.
  logic err_clr_unused;
  assign err_clr_unused = bus.err_clr;
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = cnt_q;
  assign bus.dout         = dout_q;
  assign bus.dout_vld     = dout_vld_q;

endmodule
